// File: rtl/hilo_div_ctl.sv
// EX-stage sequencer for the multi-cycle unsigned divide and the HI/LO register pair.
// Restoring division, one quotient bit per cycle; stalls HI/LO/divide users while running.
module hilo_div_ctl #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_DIVU = 4'b0011,
  parameter logic [3:0] OP_MFHI = 4'b0100,
  parameter logic [3:0] OP_MFLO = 4'b0101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_done_q, div_done_d;

  logic             hit;
  logic             start;
  logic [WIDTH:0]   t;
  logic [WIDTH+1:0] d;

  assign busy     = (state_q == RUN);
  assign hit      = ex_valid && ((alu_operation == OP_DIVU) ||
                                 (alu_operation == OP_MFHI) ||
                                 (alu_operation == OP_MFLO));
  assign stall    = hit && busy;
  assign start    = ex_valid && (alu_operation == OP_DIVU) && !busy;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_done = div_done_q;

  // Trial subtraction; the extra top bit of d is the borrow (negative result).
  always_comb begin
    t = {rem_q, quo_q[WIDTH-1]};
    d = {1'b0, t} - {2'b00, divisor_q};
  end

  // Next-state: latch operands on start, one restoring step per RUN cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d = src_b;
          quo_d     = src_a;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!d[WIDTH+1]) begin
          rem_d = d[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = t[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        // Final iteration commits straight into HI/LO on the same edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          hi_d       = rem_d;
          lo_d       = quo_d;
          div_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All sequencer state; reset discards any in-flight divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_done_q <= div_done_d;
    end
  end

  // HI/LO read mux for MFHI/MFLO.
  always_comb begin
    case (alu_operation)
      OP_MFHI: hilo_rdata = hi_q;
      OP_MFLO: hilo_rdata = lo_q;
      default: hilo_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_div_ctl.sv
// Scoreboard bench for hilo_div_ctl: divides push expected {HI,LO}; a monitor
// pops and compares on every div_done pulse. Directed checks cover stall/busy/reset.
module tb_hilo_div_ctl;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  alu_operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_done;

  int          n_checks;
  int          n_fail;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  hilo_div_ctl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_operation(alu_operation),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo), .div_done(div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic issue_divu(input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] ehi, input logic [31:0] elo);
    ex_valid      = 1'b1;
    alu_operation = OP_DIVU;
    src_a         = a;
    src_b         = b;
    if (push) sb.push_back({ehi, elo});
    @(negedge clk);
    chk("start_stall", {31'd0, stall}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd0);
    next_cycle();
  endtask

  // Monitor: every div_done pulse must match the oldest outstanding divide.
  always @(negedge clk) begin
    if (div_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL div_done_unexpected: got hi=0x%08h lo=0x%08h expected no pulse", hi, lo);
      end else begin
        mon_exp = sb.pop_front();
        chk("sb_lo", lo, mon_exp[31:0]);
        chk("sb_hi", hi, mon_exp[63:32]);
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    alu_operation = 4'b0000;
    src_a         = 32'd0;
    src_b         = 32'd0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rdata", hilo_rdata, 32'd0);
    rst = 1'b0;
    next_cycle();

    // Basic divide 100/7, with unrelated ADDs issued mid-run
    issue_divu(32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    alu_operation = OP_ADD;
    for (int c = 1; c <= 32; c++) begin
      ex_valid = (c >= 5 && c <= 8);
      @(negedge clk);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("add_no_stall", {31'd0, stall}, 32'd0);
      chk("add_rdata", hilo_rdata, 32'd0);
      next_cycle();
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk("c33_busy", {31'd0, busy}, 32'd0);
    chk("c33_done", {31'd0, div_done}, 32'd1);
    chk("c33_lo", lo, 32'd14);
    chk("c33_hi", hi, 32'd2);
    next_cycle();
    @(negedge clk);
    chk("c34_done", {31'd0, div_done}, 32'd0);
    next_cycle();

    // Divide by zero
    issue_divu(32'h12345678, 32'd0, 1'b1, 32'h12345678, 32'hFFFFFFFF);
    ex_valid = 1'b0;
    wait_cycles(32);
    @(negedge clk);
    chk("dz_done", {31'd0, div_done}, 32'd1);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'h12345678);
    next_cycle();

    // Stall then read LO
    issue_divu(32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 32'hFFFFFFFF);
    ex_valid      = 1'b1;
    alu_operation = OP_MFLO;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      chk("mflo_stall", {31'd0, stall}, 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("mflo_release", {31'd0, stall}, 32'd0);
    chk("mflo_rdata", hilo_rdata, 32'hFFFFFFFF);
    chk("mflo_hi", hi, 32'd0);
    next_cycle();
    ex_valid = 1'b0;

    // Back-to-back DIVU: second held under stall until cycle 33
    issue_divu(32'd50, 32'd5, 1'b1, 32'd0, 32'd10);
    ex_valid      = 1'b1;
    alu_operation = OP_DIVU;
    src_a         = 32'd9;
    src_b         = 32'd4;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      chk("b2b_stall", {31'd0, stall}, 32'd1);
      next_cycle();
    end
    sb.push_back({32'd1, 32'd2});
    @(negedge clk);
    chk("b2b_c33_stall", {31'd0, stall}, 32'd0);
    chk("b2b_c33_busy", {31'd0, busy}, 32'd0);
    chk("b2b_c33_lo", lo, 32'd10);
    chk("b2b_c33_hi", hi, 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c34_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    wait_cycles(31);
    @(negedge clk);
    chk("b2b_c66_done", {31'd0, div_done}, 32'd1);
    chk("b2b_c66_lo", lo, 32'd2);
    chk("b2b_c66_hi", hi, 32'd1);
    next_cycle();

    // Reset mid-run, with HI=3/LO=5 preloaded by 23/4
    issue_divu(32'd23, 32'd4, 1'b1, 32'd3, 32'd5);
    ex_valid = 1'b0;
    wait_cycles(32);
    @(negedge clk);
    chk("pre_hi", hi, 32'd3);
    chk("pre_lo", lo, 32'd5);
    next_cycle();
    issue_divu(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    ex_valid = 1'b0;
    wait_cycles(9);
    ex_valid      = 1'b1;
    alu_operation = OP_MFHI;
    #1;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_done", {31'd0, div_done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_rdata", hilo_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("post_mfhi_stall", {31'd0, stall}, 32'd0);
    chk("post_mfhi_rdata", hilo_rdata, 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("aborted_no_done", {31'd0, div_done}, 32'd0);
      next_cycle();
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctl.md
# hilo_div_ctl

Sequencer for the multi-cycle unsigned divide and the HI/LO register pair in the EX stage of the 5-stage pipeline. Accepts DIVU, MFHI and MFLO operations as decoded by the ALU control unit. Runs a 32-iteration restoring division, one quotient bit per cycle, and owns HI and LO. Raises a pipeline stall whenever an instruction that needs the divider or HI/LO arrives while a divide is still in progress.

## Interface
- WIDTH, 32, operand, quotient and remainder width; the iteration count equals WIDTH.
- OP_DIVU, 4'b0011, ALU operation code for DIVU.
- OP_MFHI, 4'b0100, ALU operation code for MFHI.
- OP_MFLO, 4'b0101, ALU operation code for MFLO.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  a valid instruction is in EX this cycle.
- alu_operation  in  4  ALU operation code from the ALU control unit.
- src_a  in  WIDTH  dividend (rs).
- src_b  in  WIDTH  divisor (rt).
- stall  out  1  combinational; freeze IF/ID/EX and insert a bubble into MEM.
- busy  out  1  registered; high while a divide is running.
- hilo_rdata  out  WIDTH  combinational; HI when the op is MFHI, LO when the op is MFLO, 0 otherwise.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).
- div_done  out  1  registered one-cycle pulse on the first cycle in which new HI/LO values are visible.

## Operation
- The state machine has two states, IDLE and RUN. It also holds a 5-bit iteration counter `cnt`, a divisor register, a partial remainder `rem` and a quotient/dividend shift register `quo`.
- `hit` = ex_valid AND alu_operation ∈ {OP_DIVU, OP_MFHI, OP_MFLO}.
- stall = hit AND busy.
- `start` = ex_valid AND alu_operation == OP_DIVU AND NOT busy.

State transitions:
- **IDLE, start:** latch divisor ← src_b, quo ← src_a, rem ← 0, cnt ← 0, then go to RUN.
- **IDLE, no start:** hold state.
- **RUN, every cycle:**
  - Form t = {rem, quo[WIDTH-1]} (WIDTH+1 bits) and d = t − {1'b0, divisor}, computed WIDTH+2 bits wide.
  - If d is non-negative: rem ← d[WIDTH-1:0], quo ← {quo[WIDTH-2:0], 1}.
  - Otherwise: rem ← t[WIDTH-1:0], quo ← {quo[WIDTH-2:0], 0}.
  - Then cnt ← cnt+1.
- **RUN, cnt == WIDTH−1:** the iteration above completes, and on the same edge HI ← final rem, LO ← final quo, div_done ← 1 (next cycle), and the state returns to IDLE.

Other rules:
- busy = (state == RUN).
- Divide by zero needs no special case. It runs the full WIDTH cycles and produces LO = all ones and HI = dividend.
- MFHI/MFLO never modify state. While not stalled, hilo_rdata reflects the current HI/LO in the same cycle.
- A DIVU arriving during RUN is stalled. It starts on the first IDLE cycle, because stall deasserts and start asserts together.
- A DIVU in IDLE overwrites HI/LO only at completion. Until then, HI/LO keep their old values and every reader of them is stalled.
- Reset at any time, including mid-RUN, forces:
  - state IDLE, cnt 0, rem 0, quo 0, divisor 0;
  - HI 0, LO 0;
  - busy 0, div_done 0.
- An in-flight divide is discarded by reset.

## Timing
- Let cycle 0 be the cycle in which start is high.
- RUN occupies cycles 1..WIDTH (cnt 0..WIDTH−1).
- HI/LO are updated on the edge that ends cycle WIDTH. New values are visible, and div_done = 1, in cycle WIDTH+1 (33 for WIDTH = 32).
- A HI/LO reader issued in cycle k, where 1 ≤ k ≤ WIDTH, is stalled for cycles k..WIDTH and completes in cycle WIDTH+1 with the new values.
- Under stall, ex_valid and alu_operation are held stable by the pipeline. The block does not register them.
- Back-to-back DIVU: the second DIVU sees start in cycle WIDTH+1 and its results appear in cycle 2·WIDTH+2.
- busy rises in cycle 1 and falls in cycle WIDTH+1.
- div_done is high for exactly one cycle per completed divide.
- Reset values of all outputs: stall 0, busy 0, div_done 0, hi 0, lo 0, hilo_rdata 0.

## Test plan
- **Basic divide:** DIVU with src_a = 100, src_b = 7 in cycle 0 → busy high cycles 1–32; in cycle 33 lo = 14, hi = 2, div_done = 1 for one cycle only.
- **Divide by zero:** DIVU 0x12345678 / 0 → cycle 33: lo = 0xFFFFFFFF, hi = 0x12345678.
- **Stall then read:**
  - DIVU 0xFFFFFFFF / 1 in cycle 0, then MFLO valid from cycle 1 → stall = 1 for cycles 1–32.
  - Cycle 33: stall = 0, hilo_rdata = 0xFFFFFFFF, hi = 0.
- **Back-to-back DIVU:**
  - DIVU 50 / 5 in cycle 0, then DIVU 9 / 4 held from cycle 1 → stall cycles 1–32.
  - Second start in cycle 33; cycle 33 shows lo = 10, hi = 0; cycle 66 shows lo = 2, hi = 1.
- **Reset mid-run:**
  - Precondition: HI = 3, LO = 5 from a prior divide.
  - DIVU 1000 / 3; assert rst asynchronously in cycle 10 → busy, stall and div_done drop immediately; hi = lo = 0.
  - After rst release, MFHI returns 0 without stall, and no div_done ever appears for the aborted divide.
- **Non-matching op while busy:** ALU_add (4'b0010) issued with ex_valid during RUN → stall = 0, hilo_rdata = 0, divide completes unaffected in cycle 33.
